// File: rtl/apb_timer_pkg.sv
// Register offsets and CTRL bit positions shared by the APB timer slave.
package apb_timer_pkg;

    localparam logic [7:0] OFS_CTRL     = 8'h00;
    localparam logic [7:0] OFS_LOAD     = 8'h04;
    localparam logic [7:0] OFS_VALUE    = 8'h08;
    localparam logic [7:0] OFS_STATUS   = 8'h0C;
    localparam logic [7:0] OFS_SCRATCH  = 8'h10;
    localparam logic [7:0] OFS_PRESCALE = 8'h14;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IE     = 2;

endpackage

// File: rtl/apb_timer_counter.sv
// Prescaler, tick generation and VALUE down-counter with expiry detection.
// A prescale of 0 gives one tick per enabled cycle.
module apb_timer_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        reload,
    input  logic [31:0] load,
    input  logic        load_wr,
    input  logic [31:0] load_wdata,
    input  logic [7:0]  prescale,
    input  logic        prescale_wr,
    output logic [31:0] value,
    output logic        expire,
    output logic        en_clr
);

    logic [7:0] pcnt;
    logic       tick;

    assign tick   = en && (pcnt == prescale);
    assign expire = tick && (value == 32'd0);
    assign en_clr = expire && !reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= 8'd0;
        end else if (!en || prescale_wr || tick) begin
            pcnt <= 8'd0;
        end else begin
            pcnt <= pcnt + 8'd1;
        end
    end

    // A LOAD write overrides whatever the tick would have done this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 32'd0;
        end else if (load_wr) begin
            value <= load_wdata;
        end else if (tick) begin
            if (value != 32'd0) begin
                value <= value - 32'd1;
            end else if (reload) begin
                value <= load;
            end
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// APB2 timer slave: decode, register bank, read mux and interrupt.
// Define APB_TIMER_PRESCALE_EN to add the PRESCALE register at 0x14.
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int SEL_IDX = 0
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Irq
);

    // Zero-wait-state APB: a write completes on the edge where sel and Penable
    // are both high; reads are driven combinationally in setup and access phases.
    logic       sel;
    logic       wr;
    logic [7:0] ofs;

    assign sel = Pselx[SEL_IDX];
    assign wr  = sel && Penable && Pwrite;
    assign ofs = {Paddr[7:2], 2'b00};

    logic unused_bits;
    assign unused_bits = ^{Paddr[31:8], Paddr[1:0], Pselx};

    logic        ctrl_en;
    logic        ctrl_reload;
    logic        ctrl_ie;
    logic [31:0] load_reg;
    logic        pend;
    logic [31:0] scratch;
    logic [31:0] value;
    logic        expire;
    logic        en_clr;
    logic [7:0]  prescale;
    logic        prescale_wr;

`ifdef APB_TIMER_PRESCALE_EN
    assign prescale_wr = wr && (ofs == OFS_PRESCALE);

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            prescale <= 8'd0;
        end else if (prescale_wr) begin
            prescale <= Pwdata[7:0];
        end
    end
`else
    assign prescale_wr = 1'b0;
    assign prescale    = 8'd0;
`endif

    apb_timer_counter u_counter (
        .clk         (Hclk),
        .rst_n       (Hresetn),
        .en          (ctrl_en),
        .reload      (ctrl_reload),
        .load        (load_reg),
        .load_wr     (wr && (ofs == OFS_LOAD)),
        .load_wdata  (Pwdata),
        .prescale    (prescale),
        .prescale_wr (prescale_wr),
        .value       (value),
        .expire      (expire),
        .en_clr      (en_clr)
    );

    // Written CTRL.en beats a one-shot clear; expiry beats a W1C of pend.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            ctrl_en     <= 1'b0;
            ctrl_reload <= 1'b0;
            ctrl_ie     <= 1'b0;
            load_reg    <= 32'd0;
            pend        <= 1'b0;
            scratch     <= 32'd0;
        end else begin
            if (wr && (ofs == OFS_CTRL)) begin
                ctrl_en     <= Pwdata[CTRL_EN];
                ctrl_reload <= Pwdata[CTRL_RELOAD];
                ctrl_ie     <= Pwdata[CTRL_IE];
            end else if (en_clr) begin
                ctrl_en <= 1'b0;
            end
            if (wr && (ofs == OFS_LOAD)) begin
                load_reg <= Pwdata;
            end
            if (expire) begin
                pend <= 1'b1;
            end else if (wr && (ofs == OFS_STATUS) && Pwdata[0]) begin
                pend <= 1'b0;
            end
            if (wr && (ofs == OFS_SCRATCH)) begin
                scratch <= Pwdata;
            end
        end
    end

    always_comb begin
        Prdata = 32'd0;
        if (sel && !Pwrite) begin
            case (ofs)
                OFS_CTRL: begin
                    Prdata[CTRL_EN]     = ctrl_en;
                    Prdata[CTRL_RELOAD] = ctrl_reload;
                    Prdata[CTRL_IE]     = ctrl_ie;
                end
                OFS_LOAD:     Prdata = load_reg;
                OFS_VALUE:    Prdata = value;
                OFS_STATUS:   Prdata[0] = pend;
                OFS_SCRATCH:  Prdata = scratch;
`ifdef APB_TIMER_PRESCALE_EN
                OFS_PRESCALE: Prdata[7:0] = prescale;
`endif
                default:      Prdata = 32'd0;
            endcase
        end
    end

    assign Irq = pend && ctrl_ie;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed and randomized checks of apb_timer_slave against a register-level model.
module tb_apb_timer_slave;

    localparam int SEL = 1;
    localparam logic [2:0] SEL_ONEHOT = 3'b010;
`ifdef APB_TIMER_PRESCALE_EN
    localparam bit PRESC = 1'b1;
`else
    localparam bit PRESC = 1'b0;
`endif

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Irq;

    int checks = 0;
    int errors = 0;

    // Model state: the programmer-visible registers plus enabled-cycle count.
    logic        m_en, m_reload, m_ie, m_pend;
    logic [31:0] m_load, m_value, m_scratch;
    logic [7:0]  m_pre;
    int          m_run;

    always #5 Hclk = ~Hclk;

    apb_timer_slave #(.SEL_IDX(SEL)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .Pselx   (Pselx),
        .Penable (Penable),
        .Pwrite  (Pwrite),
        .Paddr   (Paddr),
        .Pwdata  (Pwdata),
        .Prdata  (Prdata),
        .Irq     (Irq)
    );

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_en = 0; m_reload = 0; m_ie = 0; m_pend = 0;
        m_load = 0; m_value = 0; m_scratch = 0; m_pre = 0; m_run = 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] ofs);
        case (ofs)
            8'h00:   return {29'd0, m_ie, m_reload, m_en};
            8'h04:   return m_load;
            8'h08:   return m_value;
            8'h0C:   return {31'd0, m_pend};
            8'h10:   return m_scratch;
            8'h14:   return PRESC ? {24'd0, m_pre} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // One rising edge of the timer rules: a tick falls on every (pre+1)-th enabled cycle.
    function automatic void m_edge(input logic wr, input logic [7:0] ofs, input logic [31:0] d);
        int pre;
        logic tick, expiry, ne, np;
        logic [31:0] nv;
        pre    = PRESC ? int'(m_pre) : 0;
        tick   = m_en && ((m_run % (pre + 1)) == pre);
        expiry = tick && (m_value == 0);
        nv = m_value;
        if (tick) nv = (m_value != 0) ? m_value - 1 : (m_reload ? m_load : 32'd0);
        if (wr && ofs == 8'h04) nv = d;
        np = expiry ? 1'b1 : ((wr && ofs == 8'h0C && d[0]) ? 1'b0 : m_pend);
        ne = (expiry && !m_reload) ? 1'b0 : m_en;
        if (wr && ofs == 8'h00) ne = d[0];
        if (!m_en || (PRESC && wr && ofs == 8'h14)) m_run = 0;
        else m_run = m_run + 1;
        if (wr && ofs == 8'h00) begin
            m_reload = d[1];
            m_ie     = d[2];
        end
        if (wr && ofs == 8'h04) m_load = d;
        if (wr && ofs == 8'h10) m_scratch = d;
        if (PRESC && wr && ofs == 8'h14) m_pre = d[7:0];
        m_value = nv;
        m_pend  = np;
        m_en    = ne;
    endfunction

    task automatic cycle();
        logic wr;
        logic [7:0] ofs;
        logic [31:0] d;
        wr  = Pselx[SEL] && Penable && Pwrite;
        ofs = {Paddr[7:2], 2'b00};
        d   = Pwdata;
        @(posedge Hclk);
        if (Hresetn) m_edge(wr, ofs, d);
        #1;
    endtask

    task automatic check_bus(input string tag);
        logic [31:0] exp;
        exp = (Pselx[SEL] && !Pwrite) ? m_read({Paddr[7:2], 2'b00}) : 32'd0;
        check({tag, "_rdata"}, Prdata, exp);
        check({tag, "_irq"}, {31'd0, Irq}, {31'd0, m_pend && m_ie});
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] s = SEL_ONEHOT);
        Pselx = s; Paddr = a; Pwdata = d; Pwrite = 1; Penable = 0;
        cycle();
        Penable = 1;
        cycle();
        Pselx = 0; Penable = 0; Pwrite = 0;
    endtask

    task automatic apb_read(input logic [31:0] a, input string tag,
                            input logic [2:0] s = SEL_ONEHOT);
        Pselx = s; Paddr = a; Pwrite = 0; Penable = 0;
        #3 check_bus({tag, "_setup"});
        cycle();
        Penable = 1;
        #3 check_bus({tag, "_access"});
        cycle();
        Pselx = 0; Penable = 0;
    endtask

    // Combinational read in the setup phase, compared to a fixed value.
    task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
        Pselx = SEL_ONEHOT; Paddr = a; Pwrite = 0; Penable = 0;
        #1 check(tag, Prdata, exp);
        Pselx = 0;
    endtask

    initial begin
        logic [31:0] hi, a, d;
        logic [7:0]  o;
        logic [2:0]  s;
        int          r;

        Pselx = 0; Penable = 0; Pwrite = 0; Paddr = 0; Pwdata = 0;
        Hresetn = 0;
        m_reset();
        #1;
        for (int i = 0; i < 6; i++) begin
            peek(32'(i * 4), "reset_read", 32'd0);
            check("reset_irq", {31'd0, Irq}, 32'd0);
        end
        repeat (2) @(posedge Hclk);
        #1 Hresetn = 1;

        apb_write(32'h10, 32'hA5A5_5A5A);
        peek(32'h10, "scratch_rb", 32'hA5A5_5A5A);
        apb_write(32'h08, 32'h0000_1234);
        peek(32'h08, "value_ro", 32'd0);
        apb_read(32'h10, "scratch_rd");

        // Periodic: value after k edges is (3-k) mod 4, pend set from edge 4.
        apb_write(32'h04, 32'd3);
        apb_write(32'h00, 32'h7);
        Pselx = SEL_ONEHOT; Paddr = 32'h08; Pwrite = 0; Penable = 0;
        for (int k = 1; k <= 9; k++) begin
            cycle();
            #3 check("reload_value", Prdata, 32'((3 - k + 12) % 4));
            check("reload_irq", {31'd0, Irq}, {31'd0, k >= 4});
            check_bus("reload_model");
        end
        Pselx = 0;
        apb_write(32'h00, 32'h0);
        apb_write(32'h0C, 32'h1);
        check("clear_irq", {31'd0, Irq}, 32'd0);

        // One-shot expires on edge 3, drops en, holds VALUE at 0.
        apb_write(32'h04, 32'd2);
        apb_write(32'h00, 32'h5);
        Pselx = SEL_ONEHOT; Paddr = 32'h08; Pwrite = 0; Penable = 0;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            #3 check("oneshot_value", Prdata, (k >= 2) ? 32'd0 : 32'(2 - k));
            check("oneshot_irq", {31'd0, Irq}, {31'd0, k >= 3});
        end
        Pselx = 0;
        peek(32'h00, "oneshot_ctrl", 32'h4);
        peek(32'h0C, "oneshot_pend", 32'h1);
        apb_write(32'h0C, 32'h1);
        check("w1c_irq_drop", {31'd0, Irq}, 32'd0);

        // W1C and LOAD writes landing on expiry edges 4 and 8.
        apb_write(32'h04, 32'd3);
        apb_write(32'h00, 32'h7);
        cycle(); cycle();
        apb_write(32'h0C, 32'h1);
        peek(32'h0C, "w1c_on_expiry", 32'h1);
        cycle(); cycle();
        apb_write(32'h04, 32'd9);
        peek(32'h08, "load_on_expiry", 32'd9);
        peek(32'h0C, "load_on_expiry_pend", 32'h1);
        apb_write(32'h00, 32'h0);
        apb_write(32'h0C, 32'h1);

        // One-shot expiry on the same edge as a CTRL write setting en.
        apb_write(32'h04, 32'd1);
        apb_write(32'h00, 32'h1);
        apb_write(32'h00, 32'h1);
        peek(32'h00, "ctrl_on_expiry", 32'h1);
        peek(32'h0C, "ctrl_on_expiry_pend", 32'h1);
        apb_write(32'h00, 32'h0);
        apb_write(32'h0C, 32'h1);
        apb_read(32'h08, "after_ctrl_collide");

`ifdef APB_TIMER_PRESCALE_EN
        apb_write(32'h14, 32'd3);
        apb_write(32'h04, 32'd1);
        apb_write(32'h00, 32'h7);
        Pselx = SEL_ONEHOT; Paddr = 32'h08; Pwrite = 0; Penable = 0;
        for (int k = 1; k <= 16; k++) begin
            cycle();
            #3 check("presc_value", Prdata, ((k / 4) % 2 == 0) ? 32'd1 : 32'd0);
            check("presc_irq", {31'd0, Irq}, {31'd0, (k / 4) >= 2});
        end
        Pselx = 0;
        peek(32'h14, "presc_reg", 32'd3);
`else
        apb_write(32'h14, 32'hFF);
        peek(32'h14, "presc_unmapped", 32'd0);
`endif
        apb_write(32'h00, 32'h0);
        apb_write(32'h0C, 32'h1);

        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 9);
            hi = $urandom;
            o  = 8'($urandom_range(0, 7) * 4);
            a  = {hi[31:8], o[7:2], hi[1:0]};
            s  = ($urandom_range(0, 7) == 0) ? 3'b100 : SEL_ONEHOT;
            if (r <= 4) begin
                case (o)
                    8'h00:   d = 32'($urandom_range(0, 7));
                    8'h04:   d = 32'($urandom_range(0, 5));
                    8'h14:   d = 32'($urandom_range(0, 2));
                    default: d = $urandom;
                endcase
                apb_write(a, d, s);
            end else if (r <= 7) begin
                apb_read(a, "rand_rd", s);
            end else begin
                repeat ($urandom_range(1, 6)) begin
                    cycle();
                    check_bus("rand_idle");
                end
            end
        end

        // Reset in the middle of a count clears everything at once.
        apb_write(32'h04, 32'd100);
        apb_write(32'h00, 32'h7);
        repeat (5) cycle();
        Hresetn = 0;
        m_reset();
        for (int i = 0; i < 6; i++) begin
            peek(32'(i * 4), "midrst_read", 32'd0);
        end
        check("midrst_irq", {31'd0, Irq}, 32'd0);
        @(posedge Hclk);
        #1 Hresetn = 1;
        apb_read(32'h08, "post_reset_value");
        apb_read(32'h00, "post_reset_ctrl");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
